// File: rtl/axi_lite_master_pkg.sv
// Shared definitions for the AXI4-Lite single-outstanding master: FSM states,
// AXI response codes and register-map addresses used by the host software.
package axi_lite_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_REQ   = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_RESP  = 3'd4,
        ST_HOST_RSP = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
    localparam logic [31:0] ADDR_DATA   = 32'h0000_0040;

endpackage

// File: rtl/axi_lite_master.sv
// Host-command to AXI4-Lite bridge: one transaction in flight, AW and W issued
// together and retired independently, response held for the host until consumed.
module axi_lite_master
    import axi_lite_master_pkg::*;
(
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    state_e      state_r, next_state_s;
    logic        aw_done_r, w_done_r;
    logic [31:0] addr_r, wdata_r;
    logic [3:0]  wstrb_r;
    logic        awvalid_r, wvalid_r, arvalid_r, bready_r, rready_r, rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic [1:0]  rsp_resp_r;
    logic        accept_s, aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s, host_hs_s;

    assign cmd_ready = (state_r == ST_IDLE);
    assign accept_s  = cmd_valid & cmd_ready;
    assign aw_hs_s   = awvalid_r & M_AXI_AWREADY;
    assign w_hs_s    = wvalid_r & M_AXI_WREADY;
    assign ar_hs_s   = arvalid_r & M_AXI_ARREADY;
    assign b_hs_s    = bready_r & M_AXI_BVALID;
    assign r_hs_s    = rready_r & M_AXI_RVALID;
    assign host_hs_s = rsp_valid_r & rsp_ready;

    assign M_AXI_AWADDR  = addr_r;
    assign M_AXI_ARADDR  = addr_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = wstrb_r;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_RREADY  = rready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;

    // FSM state register
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; write phase completes when both channels have retired,
    // counting a handshake happening in the current cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
                    next_state_s = ST_WR_RESP;
                end else begin
                    next_state_s = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (b_hs_s) begin
                    next_state_s = ST_HOST_RSP;
                end else begin
                    next_state_s = ST_WR_RESP;
                end
            end
            ST_RD_REQ: begin
                if (ar_hs_s) begin
                    next_state_s = ST_RD_RESP;
                end else begin
                    next_state_s = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                if (r_hs_s) begin
                    next_state_s = ST_HOST_RSP;
                end else begin
                    next_state_s = ST_RD_RESP;
                end
            end
            ST_HOST_RSP: begin
                if (host_hs_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOST_RSP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Command capture and request channels; fields only change on accept so they
    // stay stable while any VALID is up.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            addr_r    <= 32'h0;
            wdata_r   <= 32'h0;
            wstrb_r   <= 4'h0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            arvalid_r <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else if (accept_s) begin
            addr_r    <= cmd_addr;
            wdata_r   <= cmd_wdata;
            wstrb_r   <= cmd_wstrb;
            awvalid_r <= cmd_write;
            wvalid_r  <= cmd_write;
            arvalid_r <= ~cmd_write;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                awvalid_r <= 1'b0;
                aw_done_r <= 1'b1;
            end
            if (w_hs_s) begin
                wvalid_r <= 1'b0;
                w_done_r <= 1'b1;
            end
            if (ar_hs_s) begin
                arvalid_r <= 1'b0;
            end
        end
    end

    // Response-side readies and host response capture, decoded from next state
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0;
            rsp_resp_r  <= 2'b00;
        end else begin
            bready_r    <= (next_state_s == ST_WR_RESP);
            rready_r    <= (next_state_s == ST_RD_RESP);
            rsp_valid_r <= (next_state_s == ST_HOST_RSP);
            if (b_hs_s) begin
                rsp_rdata_r <= 32'h0;
                rsp_resp_r  <= M_AXI_BRESP;
            end else if (r_hs_s) begin
                rsp_rdata_r <= M_AXI_RDATA;
                rsp_resp_r  <= M_AXI_RRESP;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed and randomized bench for axi_lite_master with a cycle-level slave and
// a beat-counting reference model of the expected bus and host behaviour.
module tb_axi_lite_master;
    import axi_lite_master_pkg::*;

    logic        M_AXI_ACLK = 1'b0;
    logic        M_AXI_ARESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0;
    logic [3:0]  cmd_wstrb = 4'h0;
    logic        cmd_ready, rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
    logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0] M_AXI_RDATA = 32'h0;

    int n_checks = 0;
    int n_fail = 0;

    axi_lite_master dut (
        .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One host transaction against a slave with per-channel delays. The model
    // tracks completed beats; expected VALID/READY follow from those counts.
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int a_dly, input int w_dly,
                           input int r_dly, input logic [1:0] resp, input logic [31:0] rdata,
                           input int hold, input bit early, input bit extra);
        int aw_n = 0, w_n = 0, ar_n = 0, k = 1, wait_cnt = 0;
        bit done = 1'b0, addr_ok;
        logic [31:0] exp_rd;
        @(negedge M_AXI_ACLK);
        chk1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        @(negedge M_AXI_ACLK);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        while (!done && k < 64) begin
            chk1("awvalid", M_AXI_AWVALID, wr && aw_n == 0);
            chk1("wvalid", M_AXI_WVALID, wr && w_n == 0);
            chk1("arvalid", M_AXI_ARVALID, !wr && ar_n == 0);
            chk1("bready", M_AXI_BREADY, wr && aw_n == 1 && w_n == 1);
            chk1("rready", M_AXI_RREADY, !wr && ar_n == 1);
            chk1("rsp_valid_busy", rsp_valid, 1'b0);
            chk1("cmd_ready_busy", cmd_ready, 1'b0);
            if (M_AXI_AWVALID) chk32("awaddr", M_AXI_AWADDR, addr);
            if (M_AXI_WVALID) chk32("wdata", M_AXI_WDATA, wdata);
            if (M_AXI_WVALID) chk32("wstrb", 32'(M_AXI_WSTRB), 32'(strb));
            if (M_AXI_ARVALID) chk32("araddr", M_AXI_ARADDR, addr);
            addr_ok = wr ? (aw_n == 1 && w_n == 1) : (ar_n == 1);
            M_AXI_AWREADY = wr && k >= a_dly;
            M_AXI_WREADY  = wr && k >= w_dly;
            M_AXI_ARREADY = !wr && k >= a_dly;
            M_AXI_BVALID  = wr && ((addr_ok && wait_cnt >= r_dly) || early);
            M_AXI_RVALID  = !wr && ((addr_ok && wait_cnt >= r_dly) || early);
            M_AXI_BRESP = resp; M_AXI_RRESP = resp; M_AXI_RDATA = rdata;
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_n++;
            if (M_AXI_WVALID && M_AXI_WREADY) w_n++;
            if (M_AXI_ARVALID && M_AXI_ARREADY) ar_n++;
            if ((M_AXI_BREADY && M_AXI_BVALID) || (M_AXI_RREADY && M_AXI_RVALID)) done = 1'b1;
            if (addr_ok) wait_cnt++;
            k++;
            @(negedge M_AXI_ACLK);
        end
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = $urandom;
        chk1("txn_timeout", done, 1'b1);
        chk32("addr_beats", wr ? aw_n : ar_n, 32'd1);
        if (wr) chk32("w_beats", w_n, 32'd1);
        exp_rd = wr ? 32'h0 : rdata;
        for (int h = 0; h <= hold; h++) begin
            chk1("rsp_valid", rsp_valid, 1'b1);
            chk32("rsp_rdata", rsp_rdata, exp_rd);
            chk32("rsp_resp", 32'(rsp_resp), 32'(resp));
            chk1("cmd_ready_hold", cmd_ready, 1'b0);
            chk1("bready_hold", M_AXI_BREADY, 1'b0);
            chk1("rready_hold", M_AXI_RREADY, 1'b0);
            rsp_ready = (h == hold);
            if (extra) begin
                cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = ADDR_STATUS;
            end
            @(negedge M_AXI_ACLK);
        end
        rsp_ready = 1'b0;
        chk1("rsp_valid_drop", rsp_valid, 1'b0);
        chk1("cmd_ready_back", cmd_ready, 1'b1);
        chk1("no_early_accept", M_AXI_ARVALID, 1'b0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        @(negedge M_AXI_ACLK);
        chk1("rst_awvalid", M_AXI_AWVALID, 1'b0);
        chk1("rst_wvalid", M_AXI_WVALID, 1'b0);
        chk1("rst_arvalid", M_AXI_ARVALID, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk32("rst_awaddr", M_AXI_AWADDR, 32'h0);
        M_AXI_ARESET = 1'b0;
        @(negedge M_AXI_ACLK);
        chk1("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Write 0x13 to 0x40, AWREADY at +2, WREADY at +4
        run_cmd(1'b1, ADDR_DATA, 32'h0000_0013, 4'hF, 2, 4, 1, RESP_OKAY, 32'h0, 0, 1'b0, 1'b0);
        // Read 0x04, data 3 cycles after the address
        run_cmd(1'b0, ADDR_STATUS, 32'h0, 4'h0, 1, 0, 3, RESP_OKAY, 32'h0000_0002, 0, 1'b0, 1'b0);
        // AWREADY and WREADY together, early stray BVALID
        run_cmd(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'h3, 3, 3, 0, RESP_OKAY, 32'h0, 0, 1'b1, 1'b0);
        // Host stalls 5 cycles with a second command waiting
        run_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0, 2, 0, 1, RESP_OKAY, 32'hCAFE_F00D, 5, 1'b0, 1'b1);
        // Error responses pass through
        run_cmd(1'b1, 32'h0000_0044, 32'h1234_5678, 4'h8, 1, 2, 2, RESP_SLVERR, 32'h0, 1, 1'b0, 1'b0);
        run_cmd(1'b0, 32'hDEAD_0000, 32'h0, 4'h0, 1, 0, 1, RESP_DECERR, 32'h5249_5343, 0, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), 2'($urandom), $urandom,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        // Reset mid-write while AWVALID is high
        @(negedge M_AXI_ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0048; cmd_wdata = 32'hFFFF_0001;
        cmd_wstrb = 4'hF;
        @(negedge M_AXI_ACLK);
        cmd_valid = 1'b0;
        @(negedge M_AXI_ACLK);
        chk1("pre_rst_awvalid", M_AXI_AWVALID, 1'b1);
        #2 M_AXI_ARESET = 1'b1;
        #1;
        chk1("async_rst_awvalid", M_AXI_AWVALID, 1'b0);
        chk1("async_rst_wvalid", M_AXI_WVALID, 1'b0);
        chk1("async_rst_bready", M_AXI_BREADY, 1'b0);
        chk32("async_rst_awaddr", M_AXI_AWADDR, 32'h0);
        chk32("async_rst_wdata", M_AXI_WDATA, 32'h0);
        @(negedge M_AXI_ACLK);
        M_AXI_ARESET = 1'b0;
        run_cmd(1'b0, ADDR_STATUS, 32'h0, 4'h0, 1, 0, 2, RESP_OKAY, 32'h0000_0077, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
